noc_credit_tx: RTL and testbench

Endpoint-side transmitter that injects packets into a router/NoC input port using the team's flit protocol: data, dest, is_tail and a one-cycle send strobe, with credit-based flow control returned by the router.
- Accepts flits from a local valid/ready stream.
- Tracks downstream buffer credits and never overruns the router input buffer.
- Holds the destination constant for every flit of a packet (wormhole).
- Sits between a client core and one NoC input port, e.g. data_in/send_in/credit_out of a ring or mesh.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_credit_counter.sv | 51 +++++
 rtl/noc_credit_tx.sv | 93 +++++++++
 tb/tb_noc_credit_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: flit bundle, transmitter states
// and the credit counter width helper.
package noc_pkg;

  localparam int NOC_DEST_W = 4;
  localparam int NOC_FLIT_W = 256;

  typedef struct packed {
    logic [NOC_FLIT_W-1:0] data;
    logic [NOC_DEST_W-1:0] dest;
    logic                  is_tail;
  } flit_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BODY = 1'b1
  } tx_state_e;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Up/down credit counter that saturates at DEPTH and
// raises a sticky error on a credit beyond the maximum.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           inc_i,
  input  logic                           dec_i,
  output logic [credit_width(DEPTH)-1:0] count_o,
  output logic                           err_o
);

  localparam int CW = credit_width(DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // inc and dec together cancel, even at the maximum
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CMAX) err_d = 1'b1;
        else               cnt_d = cnt_q + CW'(1);
      end
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CMAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign count_o = cnt_q;
  assign err_o   = err_q;

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-based flit injector: wormhole packet FSM with
// registered flit outputs toward one router input port.
module noc_credit_tx
  import noc_pkg::*;
#(
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int MAX_PACKET_FLITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [credit_width(FLIT_BUFFER_DEPTH)-1:0] credit_count,
  output logic                  idle,
  output logic                  credit_err
);

  localparam int CW  = credit_width(FLIT_BUFFER_DEPTH);
  localparam int FCW = $clog2(MAX_PACKET_FLITS + 1);
  localparam logic [FCW-1:0] FMAX = FCW'(MAX_PACKET_FLITS);

  tx_state_e             state_q, state_d;
  logic [FCW-1:0]        fcnt_q, fcnt_d, fnext;
  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q, dest_sel;
  logic                  tail_q, send_q;
  logic                  accept, tail;

  assign in_ready = (credit_count != '0);
  assign accept   = in_valid & in_ready;

  // dest_q doubles as the packet's latched head destination
  always_comb begin
    fnext    = (state_q == TX_IDLE) ? FCW'(1) : fcnt_q + FCW'(1);
    tail     = in_last | (fnext == FMAX);
    dest_sel = (state_q == TX_IDLE) ? in_dest : dest_q;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    if (accept) begin
      state_d = tail ? TX_IDLE : TX_BODY;
      fcnt_d  = tail ? '0 : fnext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      fcnt_q  <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      send_q  <= accept;
      if (accept) begin
        data_q <= in_data;
        dest_q <= dest_sel;
        tail_q <= tail;
      end
    end
  end

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_cred (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (credit_in),
    .dec_i   (accept),
    .count_o (credit_count),
    .err_o   (credit_err)
  );

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = tail_q;
  assign send_out    = send_q;
  assign idle        = (state_q == TX_IDLE) &&
                       (credit_count == CW'(FLIT_BUFFER_DEPTH));

endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed bench for noc_credit_tx: credit stalls,
// wormhole dest hold, forced tails, credit error, reset.
module tb_noc_credit_tx;

  localparam int DW = 4;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [1:0]    credit_count;
  logic          idle;
  logic          credit_err;

  logic credit_pulse;
  logic loop_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Loopback: router returns a credit in the cycle the flit arrives
  assign credit_in = loop_en ? send_out : credit_pulse;

  noc_credit_tx #(
    .DEST_WIDTH        (DW),
    .FLIT_WIDTH        (FW),
    .FLIT_BUFFER_DEPTH (2),
    .MAX_PACKET_FLITS  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_dest      (in_dest),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .is_tail_out  (is_tail_out),
    .send_out     (send_out),
    .credit_in    (credit_in),
    .credit_count (credit_count),
    .idle         (idle),
    .credit_err   (credit_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] d,
                       input logic [DW-1:0] ds, input logic l);
    in_valid = v;
    in_data  = d;
    in_dest  = ds;
    in_last  = l;
  endtask

  logic [DW-1:0] exp_dest [6];
  logic          exp_tail [6];
  logic [DW-1:0] src_dest [6];

  initial begin
    rst_n        = 1'b0;
    credit_pulse = 1'b0;
    loop_en      = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // reset state
    chk("rst_count", credit_count, 2);
    chk("rst_idle", idle, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_send", send_out, 0);
    chk("rst_err", credit_err, 0);
    chk("rst_data", data_out, 0);

    // 3-flit packet, no credit return
    drive(1'b1, 32'hA1, 4'd5, 1'b0);
    step();
    chk("p1f1_send", send_out, 1);
    chk("p1f1_data", data_out, 32'hA1);
    chk("p1f1_dest", dest_out, 5);
    chk("p1f1_tail", is_tail_out, 0);
    chk("p1f1_cnt", credit_count, 1);
    chk("p1f1_idle", idle, 0);
    drive(1'b1, 32'hA2, 4'd5, 1'b0);
    step();
    chk("p1f2_send", send_out, 1);
    chk("p1f2_data", data_out, 32'hA2);
    chk("p1f2_cnt", credit_count, 0);
    chk("p1f2_ready", in_ready, 0);
    drive(1'b1, 32'hA3, 4'd5, 1'b1);
    step();
    chk("stall_send", send_out, 0);
    chk("stall_data", data_out, 32'hA2);
    step();
    chk("stall2_send", send_out, 0);
    credit_pulse = 1'b1;
    step();
    credit_pulse = 1'b0;
    chk("cred_send", send_out, 0);
    chk("cred_cnt", credit_count, 1);
    chk("cred_ready", in_ready, 1);
    step();
    chk("p1f3_send", send_out, 1);
    chk("p1f3_data", data_out, 32'hA3);
    chk("p1f3_tail", is_tail_out, 1);
    chk("p1f3_dest", dest_out, 5);
    chk("p1f3_cnt", credit_count, 0);
    drive(1'b0, '0, '0, 1'b0);
    credit_pulse = 1'b1;
    step();
    step();
    credit_pulse = 1'b0;
    chk("p1_ret_cnt", credit_count, 2);
    chk("p1_ret_idle", idle, 1);
    chk("p1_ret_err", credit_err, 0);

    // in_dest changes mid-packet; credits looped back
    loop_en = 1'b1;
    drive(1'b1, 32'hB1, 4'd3, 1'b0);
    step();
    chk("p2f1_dest", dest_out, 3);
    chk("p2f1_cnt", credit_count, 1);
    drive(1'b1, 32'hB2, 4'd9, 1'b0);
    step();
    chk("p2f2_dest", dest_out, 3);
    chk("p2f2_data", data_out, 32'hB2);
    chk("p2f2_cnt", credit_count, 1);
    drive(1'b1, 32'hB3, 4'd9, 1'b1);
    step();
    chk("p2f3_dest", dest_out, 3);
    chk("p2f3_tail", is_tail_out, 1);
    drive(1'b1, 32'hC1, 4'd9, 1'b1);
    step();
    chk("p3_dest", dest_out, 9);
    chk("p3_tail", is_tail_out, 1);
    chk("p3_send", send_out, 1);
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("p3_ret_cnt", credit_count, 2);
    chk("p3_ret_idle", idle, 1);

    // 10 flits back to back; MAX_PACKET_FLITS=4 forces tails
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + i, 4'd6, (i == 9));
      step();
      chk($sformatf("b2b%0d_send", i), send_out, 1);
      chk($sformatf("b2b%0d_data", i), data_out, 32'h100 + i);
      chk($sformatf("b2b%0d_tail", i), is_tail_out,
          (i == 3 || i == 7 || i == 9));
      chk($sformatf("b2b%0d_cnt", i), credit_count, 1);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("b2b_end_send", send_out, 0);
    chk("b2b_end_cnt", credit_count, 2);

    // 6-flit stream: forced tail at flit 4, flit 5 is a new head
    src_dest = '{4'd2, 4'd8, 4'd8, 4'd8, 4'd7, 4'd1};
    exp_dest = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd7, 4'd7};
    exp_tail = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h200 + i, src_dest[i], (i == 5));
      step();
      chk($sformatf("frc%0d_dest", i), dest_out, exp_dest[i]);
      chk($sformatf("frc%0d_tail", i), is_tail_out, exp_tail[i]);
      chk($sformatf("frc%0d_send", i), send_out, 1);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    loop_en = 1'b0;
    chk("frc_end_cnt", credit_count, 2);

    // spurious credit while full -> sticky error
    credit_pulse = 1'b1;
    step();
    credit_pulse = 1'b0;
    chk("err_cnt", credit_count, 2);
    chk("err_set", credit_err, 1);
    drive(1'b1, 32'h300, 4'd4, 1'b0);
    step();
    chk("err_hold", credit_err, 1);
    chk("mid_send", send_out, 1);
    chk("mid_cnt", credit_count, 1);

    // reset mid-packet
    rst_n = 1'b0;
    #1;
    chk("mrst_send", send_out, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_dest", dest_out, 0);
    chk("mrst_tail", is_tail_out, 0);
    chk("mrst_cnt", credit_count, 2);
    chk("mrst_err", credit_err, 0);
    chk("mrst_idle", idle, 1);
    drive(1'b0, '0, '0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_send", send_out, 0);
    chk("post_cnt", credit_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
